// File: rtl/pb_debounce_pkg.sv
// Shared types and default parameters for the pushbutton debounce controller.
package pb_debounce_pkg;

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    PRS       = 2'd2,
    REL_CHK   = 2'd3
  } pb_state_t;

  localparam int NUM_BUTTONS_DEF    = 4;
  localparam int TICK_PERIOD_DEF    = 50000;
  localparam int DEBOUNCE_TICKS_DEF = 10;
  localparam int HOLD_TICKS_DEF     = 1000;
  localparam int REPEAT_TICKS_DEF   = 250;

  // Never returns 0 so a degenerate parameter still yields a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/pb_debounce_if.sv
// Button inputs and debounced event outputs between the debouncer and its consumer.
interface pb_debounce_if
  import pb_debounce_pkg::*;
#(
  parameter int NUM_BUTTONS = NUM_BUTTONS_DEF
);
  logic [NUM_BUTTONS-1:0] PUSH_BUTTON_N_I;
  logic                   tick_o;
  logic [NUM_BUTTONS-1:0] button_level_o;
  logic [NUM_BUTTONS-1:0] press_pulse_o;
  logic [NUM_BUTTONS-1:0] release_pulse_o;
  logic [NUM_BUTTONS-1:0] hold_pulse_o;

  modport master (
    input  PUSH_BUTTON_N_I,
    output tick_o, button_level_o, press_pulse_o, release_pulse_o, hold_pulse_o
  );

  modport slave (
    output PUSH_BUTTON_N_I,
    input  tick_o, button_level_o, press_pulse_o, release_pulse_o, hold_pulse_o
  );
endinterface

// File: rtl/pb_debounce_channel.sv
// One pushbutton: 2-flop synchroniser, debounce FSM, hold/repeat counter, registered pulses.
//   state     | meaning
//   REL       | released, waiting for a pressed sample
//   PRESS_CHK | counting consecutive pressed samples
//   PRS       | pressed, hold counter running
//   REL_CHK   | counting consecutive released samples
module pb_debounce_channel
  import pb_debounce_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int HOLD_TICKS     = HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS   = REPEAT_TICKS_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);
  localparam int SW = cnt_width(DEBOUNCE_TICKS + 1);
  localparam int HW = cnt_width(HOLD_TICKS + 1);
  localparam logic [SW-1:0] STAB_ONE    = SW'(1);
  localparam logic [SW-1:0] STAB_LAST   = SW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_TICKS - REPEAT_TICKS);

  logic [1:0]    sync_q;
  pb_state_t     state_q, state_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          hold_q, hold_d;
  logic          sample;

  assign sample = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      state_q    <= REL;
      stab_q     <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], ~btn_n_i};
      state_q    <= state_d;
      stab_q     <= stab_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    hold_d     = 1'b0;
    hold_inc   = hold_cnt_q + 1'b1;
    if (tick_i) begin
      case (state_q)
        REL: begin
          if (sample) begin
            state_d = PRESS_CHK;
            stab_d  = STAB_ONE;
          end
        end
        PRESS_CHK: begin
          if (!sample) begin
            state_d = REL;
            stab_d  = '0;
          end else if (stab_q == STAB_LAST) begin
            state_d    = PRS;
            press_d    = 1'b1;
            hold_cnt_d = '0;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
        PRS: begin
          if (!sample) begin
            state_d = REL_CHK;
            stab_d  = STAB_ONE;
          end else if (hold_inc == HOLD_LAST) begin
            hold_d     = 1'b1;
            hold_cnt_d = HOLD_RELOAD;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end
        REL_CHK: begin
          // A short release glitch returns here with the hold count untouched.
          if (sample) begin
            state_d = PRS;
          end else if (stab_q == STAB_LAST) begin
            state_d   = REL;
            release_d = 1'b1;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
        default: state_d = REL;
      endcase
    end
    level_d = (state_d == PRS) || (state_d == REL_CHK);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign hold_o    = hold_q;

endmodule

// File: rtl/pb_debounce_ctrl.sv
// Pushbutton input stage: shared sample-tick generator feeding independent debounce channels.
module pb_debounce_ctrl
  import pb_debounce_pkg::*;
#(
  parameter int NUM_BUTTONS    = NUM_BUTTONS_DEF,
  parameter int TICK_PERIOD    = TICK_PERIOD_DEF,
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int HOLD_TICKS     = HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS   = REPEAT_TICKS_DEF
) (
  input  logic          CLOCK_50_I,
  input  logic          reset,
  pb_debounce_if.master bus
);
  localparam int TW = cnt_width(TICK_PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);

  if (DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1 || HOLD_TICKS < REPEAT_TICKS || TICK_PERIOD < 1)
  begin : g_param_check
    $fatal(1, "pb_debounce_ctrl: illegal debounce/hold/repeat/tick parameters");
  end

  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic                   tick;
  logic [NUM_BUTTONS-1:0] level, press, release_p, hold;

  assign tick       = (tick_cnt_q == TICK_LAST);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    pb_debounce_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .HOLD_TICKS     (HOLD_TICKS),
      .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_ch (
      .clk_i     (CLOCK_50_I),
      .rst_i     (reset),
      .tick_i    (tick),
      .btn_n_i   (bus.PUSH_BUTTON_N_I[i]),
      .level_o   (level[i]),
      .press_o   (press[i]),
      .release_o (release_p[i]),
      .hold_o    (hold[i])
    );
  end

  assign bus.tick_o          = tick;
  assign bus.button_level_o  = level;
  assign bus.press_pulse_o   = press;
  assign bus.release_pulse_o = release_p;
  assign bus.hold_pulse_o    = hold;

endmodule

// File: tb/tb_pb_debounce_ctrl.sv
// Directed bench for pb_debounce_ctrl: expected pulse events are queued as stimulus is driven.
module tb_pb_debounce_ctrl;
  localparam int NB  = 4;
  localparam int TP  = 4;
  localparam int DEB = 3;
  localparam int HLD = 8;
  localparam int REP = 2;

  typedef struct {
    int       tick;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] hld;
  } ev_t;

  logic CLOCK_50_I = 1'b0;
  logic reset      = 1'b1;
  int   errors     = 0;
  int   checks     = 0;
  int   tick_n     = 0;
  int   cyc        = 0;
  int   last_tick  = -1;
  ev_t  exp_q[$];
  ev_t  ev;

  pb_debounce_if #(.NUM_BUTTONS(NB)) bus ();

  pb_debounce_ctrl #(
    .NUM_BUTTONS    (NB),
    .TICK_PERIOD    (TP),
    .DEBOUNCE_TICKS (DEB),
    .HOLD_TICKS     (HLD),
    .REPEAT_TICKS   (REP)
  ) dut (
    .CLOCK_50_I (CLOCK_50_I),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int t, input logic [3:0] p, input logic [3:0] r, input logic [3:0] h);
    ev_t e;
    e.tick = t; e.prs = p; e.rel = r; e.hld = h;
    exp_q.push_back(e);
  endtask

  // Monitor: counts ticks, checks the tick period, and pops the scoreboard on every pulse.
  always @(negedge CLOCK_50_I) begin
    cyc++;
    if (reset) begin
      last_tick = -1;
    end else if (bus.tick_o) begin
      tick_n++;
      if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), TP);
      last_tick = cyc;
    end
    if ((bus.press_pulse_o | bus.release_pulse_o | bus.hold_pulse_o) != 4'h0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {20'h0, bus.press_pulse_o, bus.release_pulse_o, bus.hold_pulse_o}, 32'h0);
      end else begin
        ev = exp_q.pop_front();
        check("event_tick", tick_n, ev.tick);
        check("press_pulse", {28'h0, bus.press_pulse_o}, {28'h0, ev.prs});
        check("release_pulse", {28'h0, bus.release_pulse_o}, {28'h0, ev.rel});
        check("hold_pulse", {28'h0, bus.hold_pulse_o}, {28'h0, ev.hld});
      end
    end
  end

  task automatic step();
    @(negedge CLOCK_50_I);
    #1;
  endtask

  task automatic wait_tick_n(input int n);
    int budget = 0;
    while (tick_n < n && budget < 2000) begin
      step();
      budget++;
    end
    if (tick_n < n) check("wait_timeout", tick_n, n);
  endtask

  task automatic wait_ticks(input int k);
    wait_tick_n(tick_n + k);
  endtask

  // Press mask m, keep it held H ticks past the press pulse, then release.
  task automatic press_hold(input logic [3:0] m, input int h, input string tag);
    int t, p;
    wait_ticks(1);
    t = tick_n;
    bus.PUSH_BUTTON_N_I = bus.PUSH_BUTTON_N_I & ~m;
    p = t + DEB;
    push(p, m, 4'h0, 4'h0);
    for (int k = HLD; k <= h; k += REP) push(p + k, 4'h0, 4'h0, m);
    wait_tick_n(p);
    step();
    check({tag, "_level_pressed"}, {28'h0, bus.button_level_o}, {28'h0, m});
    wait_tick_n(p + h);
    bus.PUSH_BUTTON_N_I = bus.PUSH_BUTTON_N_I | m;
    push(p + h + DEB, 4'h0, m, 4'h0);
    wait_tick_n(p + h + DEB);
    step();
    check({tag, "_level_released"}, {28'h0, bus.button_level_o}, 32'h0);
  endtask

  initial begin
    int t, p;
    bus.PUSH_BUTTON_N_I = 4'hF;
    reset = 1'b1;
    repeat (3) step();
    check("rst_level", {28'h0, bus.button_level_o}, 32'h0);
    check("rst_press", {28'h0, bus.press_pulse_o}, 32'h0);
    check("rst_release", {28'h0, bus.release_pulse_o}, 32'h0);
    check("rst_hold", {28'h0, bus.hold_pulse_o}, 32'h0);
    check("rst_tick", {31'h0, bus.tick_o}, 32'h0);
    reset = 1'b0;

    press_hold(4'b0001, 7, "clean");

    // Bounce on bit 1: 6-cycle period against a 4-cycle tick never gives 3 agreeing samples.
    wait_ticks(1);
    for (int r = 0; r < 5; r++) begin
      bus.PUSH_BUTTON_N_I[1] = 1'b0;
      repeat (3) begin step(); check("bounce_level", {28'h0, bus.button_level_o}, 32'h0); end
      bus.PUSH_BUTTON_N_I[1] = 1'b1;
      repeat (3) begin step(); check("bounce_level", {28'h0, bus.button_level_o}, 32'h0); end
    end
    wait_ticks(DEB + 2);
    check("bounce_final_level", {28'h0, bus.button_level_o}, 32'h0);

    press_hold(4'b0100, 16, "hold");

    // Release glitch on bit 3: one released sample, then pressed again.
    wait_ticks(1);
    t = tick_n;
    bus.PUSH_BUTTON_N_I[3] = 1'b0;
    p = t + DEB;
    push(p, 4'b1000, 4'h0, 4'h0);
    push(p + 10, 4'h0, 4'h0, 4'b1000);
    push(p + 12, 4'h0, 4'h0, 4'b1000);
    wait_tick_n(p + 3);
    bus.PUSH_BUTTON_N_I[3] = 1'b1;
    wait_tick_n(p + 4);
    bus.PUSH_BUTTON_N_I[3] = 1'b0;
    step();
    check("glitch_level_held", {28'h0, bus.button_level_o}, 32'h8);
    wait_tick_n(p + 12);
    bus.PUSH_BUTTON_N_I[3] = 1'b1;
    push(p + 12 + DEB, 4'h0, 4'b1000, 4'h0);
    wait_tick_n(p + 12 + DEB);
    step();
    check("glitch_level_released", {28'h0, bus.button_level_o}, 32'h0);

    press_hold(4'hF, 3, "simul");

    // Reset while bit 0 is held past its first hold pulse.
    wait_ticks(1);
    t = tick_n;
    bus.PUSH_BUTTON_N_I[0] = 1'b0;
    p = t + DEB;
    push(p, 4'b0001, 4'h0, 4'h0);
    push(p + HLD, 4'h0, 4'h0, 4'b0001);
    wait_tick_n(p + HLD + 1);
    step();
    reset = 1'b1;
    step();
    check("midrst_level", {28'h0, bus.button_level_o}, 32'h0);
    check("midrst_press", {28'h0, bus.press_pulse_o}, 32'h0);
    check("midrst_release", {28'h0, bus.release_pulse_o}, 32'h0);
    check("midrst_hold", {28'h0, bus.hold_pulse_o}, 32'h0);
    reset = 1'b0;
    t = tick_n;
    push(t + DEB, 4'b0001, 4'h0, 4'h0);
    wait_tick_n(t + DEB);
    step();
    check("postrst_level", {28'h0, bus.button_level_o}, 32'h1);
    t = tick_n;
    bus.PUSH_BUTTON_N_I[0] = 1'b1;
    push(t + DEB, 4'h0, 4'b0001, 4'h0);
    wait_tick_n(t + DEB);
    step();
    check("postrst_level_released", {28'h0, bus.button_level_o}, 32'h0);

    wait_ticks(20);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
